mult_array: RTL and testbench
=============================

MULT_ARRAY -- requirements
Module: mult_array

Interface
REQ-001 Parameter DATA_WID, default 16: operand and result width in bits, signed two's complement.
REQ-002 Parameter MUL_NUM, default 8: number of parallel multiplier lanes.
REQ-003 Parameter AUG_FCT_B, default 7: number of fractional bits of operand B; the product is scaled down by 2^AUG_FCT_B.
REQ-004 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port A, input, MUL_NUM x DATA_WID signed, unpacked array [MUL_NUM-1:0]: lane multiplicands.
REQ-007 Port B, input, MUL_NUM x DATA_WID signed, unpacked array [MUL_NUM-1:0]: lane multipliers, fixed-point with AUG_FCT_B fractional bits.
REQ-008 Port status_in, input, PE_STATE: status tag of the current operands.
REQ-009 Port status_out, output, PE_STATE: status tag aligned with OUT.
REQ-010 Port OUT, output, MUL_NUM x DATA_WID signed, unpacked array [MUL_NUM-1:0]: lane results.

Function
REQ-011 Each lane i SHALL form the full 2*DATA_WID-bit signed product A[i]*B[i].
REQ-012 The product SHALL be arithmetically shifted right by AUG_FCT_B, which rounds toward minus infinity with no rounding increment.
REQ-013 The shifted value SHALL be saturated to the DATA_WID signed range: max 0x7FFF and min 0x8000 for DATA_WID=16.
REQ-014 The lane result SHALL be registered, giving exactly 1 cycle of latency from the input sample edge to OUT.
REQ-015 status_out SHALL be status_in registered on every rising edge, so it stays aligned with OUT.
REQ-016 OUT[i] SHALL load the new lane result only when status_in != INVALID.
REQ-017 When status_in == INVALID, OUT SHALL hold its previous value, while status_out still updates to INVALID.
REQ-018 VALID, FINISH and COMPL SHALL be treated identically for arithmetic; the block only passes these tags through.
REQ-019 All lanes SHALL operate independently and in parallel, with no cross-lane interaction.
REQ-020 Operands SHALL be accepted every cycle, with no back-pressure.

Reset
REQ-021 While reset=1 at a rising edge, every OUT[i] SHALL become 0 and status_out SHALL become INVALID.
REQ-022 Reset SHALL take priority over status_in and the operands.
REQ-023 An assertion of reset mid-stream SHALL discard the in-flight result.
REQ-024 The first post-reset result SHALL appear 1 cycle after the first non-INVALID sample.

Structure
REQ-025 The PE_STATE enum SHALL live in the shared PE package as a 2-bit enum: INVALID=0, VALID=1, FINISH=2, COMPL=3.
REQ-026 The PE package SHALL be imported by mult_array.
REQ-027 One sub-module, mult_lane, SHALL implement the multiply, shift and saturate datapath for one lane.
REQ-028 mult_lane SHALL be instantiated MUL_NUM times through a generate loop.
REQ-029 mult_lane SHALL be combinational; the output and status registers SHALL live in mult_array.

Verification
REQ-030 Reset scenario: hold reset=1 for 2 cycles with status_in=INVALID and A[0]=0x00AA, B[0]=0x0092 -> OUT all 0 and status_out=INVALID throughout.
REQ-031 Small-value scenario: release reset, then apply VALID with A[0]=0x0001, B[0]=0x0011 -> next cycle OUT[0]=0x0000 and status_out=VALID.
REQ-032 Positive saturation scenario: apply FINISH with A[0]=0xF0FF, B[0]=0xF0FF -> next cycle OUT[0]=0x7FFF (saturated) and status_out=FINISH.
REQ-033 Positive saturation scenario: apply COMPL with A[0]=0xF050, B[0]=0xF034 -> next cycle OUT[0]=0x7FFF (saturated) and status_out=COMPL.
REQ-034 Negative floor scenario: apply COMPL with A[0]=0x80A8, B[0]=0x0024 -> OUT[0]=0xDC2F (-9169); then apply A[0]=0xFFFD, B[0]=0x00A0 -> OUT[0]=0xFFFC (-4).
REQ-035 Hold and lane-independence scenario: apply status_in=INVALID with new operands -> OUT unchanged and status_out=INVALID.
REQ-036 In the same scenario, lanes 1..7 driven with distinct values SHALL match the per-lane reference model, with negative saturation A=0x8000, B=0x7FFF -> 0x8000.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared processing-element definitions: the status tag that travels
// alongside operands through the PE datapaths.
package pe_pkg;

    typedef enum logic [1:0] {
        INVALID = 2'd0,
        VALID   = 2'd1,
        FINISH  = 2'd2,
        COMPL   = 2'd3
    } PE_STATE;

endpackage

// File: rtl/mult_array_lane.sv
// One multiplier lane: full-width signed product, arithmetic right shift
// by the fractional bits of B (floor rounding), then saturation back to
// DATA_WID bits. Purely combinational; the parent registers the result.
module mult_lane #(
    parameter int DATA_WID  = 16,
    parameter int AUG_FCT_B = 7
) (
    input  logic signed [DATA_WID-1:0] a,
    input  logic signed [DATA_WID-1:0] b,
    output logic signed [DATA_WID-1:0] y
);

    localparam int PW = 2 * DATA_WID;

    // Saturation bounds expressed at product width so the comparison is exact.
    localparam logic signed [PW-1:0] SAT_MAX = {{(DATA_WID + 1){1'b0}}, {(DATA_WID - 1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(DATA_WID + 1){1'b1}}, {(DATA_WID - 1){1'b0}}};

    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shifted;

    assign a_ext   = {{DATA_WID{a[DATA_WID-1]}}, a};
    assign b_ext   = {{DATA_WID{b[DATA_WID-1]}}, b};
    assign prod    = a_ext * b_ext;
    // Arithmetic shift drops fractional bits toward minus infinity.
    assign shifted = prod >>> AUG_FCT_B;

    // Clamp the scaled product into the DATA_WID signed range.
    always_comb begin
        y = shifted[DATA_WID-1:0];
        if (shifted > SAT_MAX) begin
            y = SAT_MAX[DATA_WID-1:0];
        end else if (shifted < SAT_MIN) begin
            y = SAT_MIN[DATA_WID-1:0];
        end
    end

endmodule

// File: rtl/mult_array.sv
// Array of independent fixed-point multiplier lanes with a one-cycle
// registered output. The status tag is pipelined alongside the results;
// an INVALID tag leaves the lane results untouched.
module mult_array
    import pe_pkg::*;
#(
    parameter int DATA_WID  = 16,
    parameter int MUL_NUM   = 8,
    parameter int AUG_FCT_B = 7
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic signed [DATA_WID-1:0] A [MUL_NUM-1:0],
    input  logic signed [DATA_WID-1:0] B [MUL_NUM-1:0],
    input  PE_STATE                    status_in,
    output PE_STATE                    status_out,
    output logic signed [DATA_WID-1:0] OUT [MUL_NUM-1:0]
);

    logic signed [DATA_WID-1:0] lane_res [MUL_NUM-1:0];
    logic signed [DATA_WID-1:0] out_reg  [MUL_NUM-1:0];
    PE_STATE                    status_reg;

    genvar gi;
    generate
        for (gi = 0; gi < MUL_NUM; gi++) begin : g_lane
            mult_lane #(
                .DATA_WID  (DATA_WID),
                .AUG_FCT_B (AUG_FCT_B)
            ) u_lane (
                .a (A[gi]),
                .b (B[gi]),
                .y (lane_res[gi])
            );

            // Lane result register: loads on any non-INVALID tag, otherwise holds.
            always_ff @(posedge clk) begin
                if (reset) begin
                    out_reg[gi] <= '0;
                end else if (status_in != INVALID) begin
                    out_reg[gi] <= lane_res[gi];
                end
            end

            assign OUT[gi] = out_reg[gi];
        end
    endgenerate

    // Status tag follows the operands every cycle so it stays aligned with OUT.
    always_ff @(posedge clk) begin
        if (reset) begin
            status_reg <= INVALID;
        end else begin
            status_reg <= status_in;
        end
    end

    assign status_out = status_reg;

endmodule

// File: tb/tb_mult_array.sv
// Self-checking bench for mult_array: directed scenarios plus randomized
// traffic against a plain-arithmetic reference model.
module tb_mult_array;
    import pe_pkg::*;

    localparam int W = 16;
    localparam int N = 8;
    localparam int F = 7;

    logic                clk = 1'b0;
    logic                reset;
    logic signed [W-1:0] A   [N-1:0];
    logic signed [W-1:0] B   [N-1:0];
    logic signed [W-1:0] OUT [N-1:0];
    PE_STATE             status_in;
    PE_STATE             status_out;

    int n_tests = 0;
    int n_fail  = 0;

    logic signed [W-1:0] exp_out [N];
    PE_STATE             exp_st;

    mult_array #(
        .DATA_WID  (W),
        .MUL_NUM   (N),
        .AUG_FCT_B (F)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .A          (A),
        .B          (B),
        .status_in  (status_in),
        .status_out (status_out),
        .OUT        (OUT)
    );

    always #5 clk = ~clk;

    // Reference: exact integer product, floor-divided by 2^F, clamped.
    function automatic logic signed [W-1:0] ref_mul(input logic signed [W-1:0] a,
                                                    input logic signed [W-1:0] b);
        longint p;
        longint q;
        longint lim_hi;
        longint lim_lo;
        p = longint'(a) * longint'(b);
        q = p / (longint'(1) << F);
        if ((p % (longint'(1) << F)) != 0 && p < 0) q = q - 1;
        lim_hi = (longint'(1) << (W - 1)) - 1;
        lim_lo = -(longint'(1) << (W - 1));
        if (q > lim_hi) q = lim_hi;
        if (q < lim_lo) q = lim_lo;
        return q[W-1:0];
    endfunction

    // Apply current A/B with given reset/status for one edge and advance the model.
    task automatic step(input logic rst, input PE_STATE st);
        reset     = rst;
        status_in = st;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < N; i++) exp_out[i] = '0;
            exp_st = INVALID;
        end else begin
            exp_st = st;
            if (st != INVALID)
                for (int i = 0; i < N; i++) exp_out[i] = ref_mul(A[i], B[i]);
        end
        #1;
    endtask

    function automatic logic [W-1:0] pick_val();
        case ($urandom_range(0, 7))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            2:       return 16'hFFFF;
            3:       return 16'h0000;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic fill_lanes(input int first);
        for (int i = first; i < N; i++) begin
            A[i] = pick_val();
            B[i] = pick_val();
        end
    endtask

    task automatic test_reset();
        A[0] = 16'h00AA;
        B[0] = 16'h0092;
        fill_lanes(1);
        for (int c = 0; c < 2; c++) begin
            step(1'b1, INVALID);
            for (int i = 0; i < N; i++) begin
                n_tests++;
                if (OUT[i] !== 16'h0000) begin
                    n_fail++;
                    $display("FAIL reset_out lane %0d cycle %0d: got %h want 0000", i, c, OUT[i]);
                end
            end
            n_tests++;
            if (status_out !== INVALID) begin
                n_fail++;
                $display("FAIL reset_status cycle %0d: got %0d want INVALID", c, status_out);
            end
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_small();
        A[0] = 16'h0001;
        B[0] = 16'h0011;
        fill_lanes(1);
        step(1'b0, VALID);
        n_tests++;
        if (OUT[0] !== 16'h0000 || status_out !== VALID) begin
            n_fail++;
            $display("FAIL small: got OUT0=%h st=%0d want 0000 st=VALID", OUT[0], status_out);
        end
        for (int i = 1; i < N; i++) begin
            n_tests++;
            if (OUT[i] !== exp_out[i]) begin
                n_fail++;
                $display("FAIL small_lane %0d: got %h want %h", i, OUT[i], exp_out[i]);
            end
        end
        $display("[TB] test_small done");
    endtask

    task automatic test_pos_sat();
        A[0] = 16'hF0FF;
        B[0] = 16'hF0FF;
        step(1'b0, FINISH);
        n_tests++;
        if (OUT[0] !== 16'h7FFF || status_out !== FINISH) begin
            n_fail++;
            $display("FAIL pos_sat1: got OUT0=%h st=%0d want 7fff st=FINISH", OUT[0], status_out);
        end
        A[0] = 16'hF050;
        B[0] = 16'hF034;
        step(1'b0, COMPL);
        n_tests++;
        if (OUT[0] !== 16'h7FFF || status_out !== COMPL) begin
            n_fail++;
            $display("FAIL pos_sat2: got OUT0=%h st=%0d want 7fff st=COMPL", OUT[0], status_out);
        end
        $display("[TB] test_pos_sat done");
    endtask

    task automatic test_neg_floor();
        A[0] = 16'h80A8;
        B[0] = 16'h0024;
        step(1'b0, COMPL);
        n_tests++;
        if (OUT[0] !== 16'hDC2F) begin
            n_fail++;
            $display("FAIL neg_floor1: got %h want dc2f", OUT[0]);
        end
        A[0] = 16'hFFFD;
        B[0] = 16'h00A0;
        step(1'b0, COMPL);
        n_tests++;
        if (OUT[0] !== 16'hFFFC) begin
            n_fail++;
            $display("FAIL neg_floor2: got %h want fffc", OUT[0]);
        end
        $display("[TB] test_neg_floor done");
    endtask

    task automatic test_hold();
        logic signed [W-1:0] snap [N];
        // Distinct values on lanes 1..7, lane 7 forced into negative saturation.
        A[0] = 16'h0100; B[0] = 16'h0080;
        for (int i = 1; i < N - 1; i++) begin
            A[i] = W'(16'h0123 * i - 16'h0400);
            B[i] = W'(16'h0041 + 16'h0107 * i);
        end
        A[N-1] = 16'h8000;
        B[N-1] = 16'h7FFF;
        step(1'b0, VALID);
        n_tests++;
        if (OUT[N-1] !== 16'h8000) begin
            n_fail++;
            $display("FAIL neg_sat: got %h want 8000", OUT[N-1]);
        end
        for (int i = 0; i < N; i++) begin
            n_tests++;
            if (OUT[i] !== exp_out[i]) begin
                n_fail++;
                $display("FAIL lane_indep %0d: got %h want %h", i, OUT[i], exp_out[i]);
            end
            snap[i] = exp_out[i];
        end
        fill_lanes(0);
        step(1'b0, INVALID);
        n_tests++;
        if (status_out !== INVALID) begin
            n_fail++;
            $display("FAIL hold_status: got %0d want INVALID", status_out);
        end
        for (int i = 0; i < N; i++) begin
            n_tests++;
            if (OUT[i] !== snap[i]) begin
                n_fail++;
                $display("FAIL hold_lane %0d: got %h want %h", i, OUT[i], snap[i]);
            end
        end
        $display("[TB] test_hold done");
    endtask

    task automatic test_back_to_back();
        PE_STATE st;
        logic    rst;
        for (int c = 0; c < 300; c++) begin
            fill_lanes(0);
            st  = PE_STATE'($urandom_range(0, 3));
            rst = ($urandom_range(0, 24) == 0);
            step(rst, st);
            n_tests++;
            if (status_out !== exp_st) begin
                n_fail++;
                $display("FAIL b2b_status cycle %0d: got %0d want %0d", c, status_out, exp_st);
            end
            for (int i = 0; i < N; i++) begin
                n_tests++;
                if (OUT[i] !== exp_out[i]) begin
                    n_fail++;
                    $display("FAIL b2b_lane %0d cycle %0d: got %h want %h", i, c, OUT[i], exp_out[i]);
                end
            end
        end
        $display("[TB] test_back_to_back done");
    endtask

    task automatic test_mid_reset();
        fill_lanes(0);
        A[0] = 16'h1234;
        B[0] = 16'h0200;
        step(1'b0, VALID);
        fill_lanes(0);
        step(1'b1, VALID);
        n_tests++;
        if (status_out !== INVALID) begin
            n_fail++;
            $display("FAIL mid_reset_status: got %0d want INVALID", status_out);
        end
        for (int i = 0; i < N; i++) begin
            n_tests++;
            if (OUT[i] !== 16'h0000) begin
                n_fail++;
                $display("FAIL mid_reset_lane %0d: got %h want 0000", i, OUT[i]);
            end
        end
        // First non-INVALID sample after reset shows up one cycle later.
        A[0] = 16'h0300;
        B[0] = 16'h0100;
        step(1'b0, VALID);
        n_tests++;
        if (OUT[0] !== 16'h0600 || status_out !== VALID) begin
            n_fail++;
            $display("FAIL post_reset_first: got OUT0=%h st=%0d want 0600 st=VALID", OUT[0], status_out);
        end
        $display("[TB] test_mid_reset done");
    endtask

    initial begin
        reset     = 1'b1;
        status_in = INVALID;
        for (int i = 0; i < N; i++) begin
            A[i]       = '0;
            B[i]       = '0;
            exp_out[i] = '0;
        end
        exp_st = INVALID;
        @(posedge clk);
        #1;
        test_reset();
        test_small();
        test_pos_sat();
        test_neg_floor();
        test_hold();
        test_mid_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
